// File: rtl/coin_acceptor.sv
// Coin-chute front end: synchronise and debounce the sensor, measure pulse width,
// classify each coin as Rs5/Rs10, and flag rejects and sensor jams.
module coin_acceptor #(
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned DEB_CYCLES = 4,
   parameter int unsigned T5_MIN     = 20,
   parameter int unsigned T5_MAX     = 40,
   parameter int unsigned T10_MIN    = 60,
   parameter int unsigned T10_MAX    = 90,
   parameter int unsigned TIMEOUT    = 255,
   parameter int unsigned GAP        = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       coin_sense,
   input  logic       accept_en,
   output logic [1:0] coin_code,
   output logic       coin_valid,
   output logic       coin_reject,
   output logic       jam
);

   localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
   localparam int unsigned GAP_W = $clog2(GAP + 1);

   typedef enum logic [2:0] {IDLE, MEASURE, DONE, JAMMED, LOCKOUT} state_t;

   state_t             state;
   logic               sync1;
   logic               s;
   logic               f;
   logic [DEB_W-1:0]   deb_cnt;
   logic [CNT_W-1:0]   width;
   logic               taint;
   logic [GAP_W-1:0]   gap_cnt;

   logic in_rs5;
   logic in_rs10;

   assign in_rs5  = (width >= CNT_W'(T5_MIN))  && (width <= CNT_W'(T5_MAX));
   assign in_rs10 = (width >= CNT_W'(T10_MIN)) && (width <= CNT_W'(T10_MAX));

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1       <= 1'b0;
         s           <= 1'b0;
         f           <= 1'b0;
         deb_cnt     <= '0;
         width       <= '0;
         taint       <= 1'b0;
         gap_cnt     <= '0;
         state       <= IDLE;
         coin_code   <= 2'b00;
         coin_valid  <= 1'b0;
         coin_reject <= 1'b0;
         jam         <= 1'b0;
      end else begin
         sync1 <= coin_sense;
         s     <= sync1;

         // Filtered level moves only after DEB_CYCLES consecutive disagreeing samples.
         if (s == f) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
            f       <= s;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end

         coin_code   <= 2'b00;
         coin_valid  <= 1'b0;
         coin_reject <= 1'b0;

         case (state)
            IDLE: begin
               if (f) begin
                  state <= MEASURE;
                  width <= CNT_W'(1);
                  taint <= ~accept_en;
               end
            end
            MEASURE: begin
               if (!f) begin
                  state <= DONE;
               end else if (width == CNT_W'(TIMEOUT)) begin
                  state <= JAMMED;
                  jam   <= 1'b1;
               end else begin
                  width <= width + 1'b1;
               end
            end
            DONE: begin
               if (taint) begin
                  coin_reject <= 1'b1;
               end else if (in_rs5) begin
                  coin_code  <= 2'b01;
                  coin_valid <= 1'b1;
               end else if (in_rs10) begin
                  coin_code  <= 2'b10;
                  coin_valid <= 1'b1;
               end else begin
                  coin_reject <= 1'b1;
               end
               state   <= LOCKOUT;
               gap_cnt <= '0;
            end
            JAMMED: begin
               if (!f) begin
                  jam         <= 1'b0;
                  coin_reject <= 1'b1;
                  state       <= LOCKOUT;
                  gap_cnt     <= '0;
               end
            end
            LOCKOUT: begin
               if (gap_cnt == GAP_W'(GAP - 1)) begin
                  // A coin already present at lockout exit lost its leading edge: force reject.
                  if (f) begin
                     state <= MEASURE;
                     width <= CNT_W'(1);
                     taint <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: stimulus pushes expected events with their
// due cycle; a negedge monitor pops and checks each event the DUT presents.
module tb_coin_acceptor;

   localparam int DEB     = 4;
   localparam int LAT     = 2 + DEB + 2;   // raw fall -> coin event
   localparam int LAT_JAM = LAT - 1;       // raw fall -> jam release reject
   localparam int JAM_RISE = 2 + DEB + 256; // raw rise -> jam high (width reaches 255, then JAM)

   localparam int K_RS5   = 1;
   localparam int K_RS10  = 2;
   localparam int K_REJ   = 3;
   localparam int K_JAM   = 4;

   typedef struct {
      int kind;
      int due;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       coin_sense = 1'b0;
   logic       accept_en = 1'b1;
   logic [1:0] coin_code;
   logic       coin_valid;
   logic       coin_reject;
   logic       jam;

   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   logic jam_prev = 1'b0;
   exp_t exp_q[$];

   coin_acceptor #(
      .CNT_W(8), .DEB_CYCLES(DEB), .T5_MIN(20), .T5_MAX(40),
      .T10_MIN(60), .T10_MAX(90), .TIMEOUT(255), .GAP(16)
   ) dut (
      .clk(clk), .rst(rst), .coin_sense(coin_sense), .accept_en(accept_en),
      .coin_code(coin_code), .coin_valid(coin_valid),
      .coin_reject(coin_reject), .jam(jam)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   function automatic void push(input int kind, input int due);
      exp_t e;
      e.kind = kind;
      e.due  = due;
      exp_q.push_back(e);
   endfunction

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Drive a clean raw pulse of n sampled-high cycles; kind 0 means no event expected.
   task automatic coin(input int n, input int kind);
      coin_sense = 1'b1;
      idle(n);
      coin_sense = 1'b0;
      if (kind != 0) push(kind, cyc + LAT);
      idle(40);
   endtask

   // Event monitor
   always @(negedge clk) begin
      if (!rst) begin
         int   act_kind;
         exp_t e;
         check("outputs_consistent",
               int'((coin_code != 2'b11) && (coin_valid == (coin_code != 2'b00)) &&
                    !(coin_valid && coin_reject) && !(jam && (coin_valid || coin_reject))), 1);
         act_kind = 0;
         if (coin_valid)       act_kind = int'(coin_code);
         else if (coin_reject) act_kind = K_REJ;
         else if (jam && !jam_prev) act_kind = K_JAM;
         if (act_kind != 0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_event", act_kind, 0);
            end else begin
               e = exp_q.pop_front();
               check("event_kind", act_kind, e.kind);
               check("event_cycle", cyc, e.due);
            end
         end
         jam_prev <= jam;
      end else begin
         jam_prev <= 1'b0;
      end
   end

   initial begin
      rst = 1'b1;
      idle(3);
      check("reset_code", int'(coin_code), 0);
      check("reset_valid", int'(coin_valid), 0);
      check("reset_reject", int'(coin_reject), 0);
      check("reset_jam", int'(jam), 0);
      rst = 1'b0;
      idle(10);

      // Basic Rs5, Rs10 and width boundaries
      coin(30, K_RS5);
      coin(60, K_RS10);
      coin(90, K_RS10);
      coin(20, K_RS5);
      coin(40, K_RS5);
      coin(19, K_REJ);
      coin(41, K_REJ);
      coin(59, K_REJ);
      coin(91, K_REJ);

      // 30-cycle span with two 3-cycle dropouts, then an isolated 3-cycle spike
      coin_sense = 1'b1; idle(8);
      coin_sense = 1'b0; idle(3);
      coin_sense = 1'b1; idle(8);
      coin_sense = 1'b0; idle(3);
      coin_sense = 1'b1; idle(8);
      coin_sense = 1'b0;
      push(K_RS5, cyc + LAT);
      idle(40);
      coin(3, 0);

      // Acceptance disabled at coin start, enabled mid-coin
      accept_en = 1'b0;
      coin_sense = 1'b1; idle(20);
      accept_en = 1'b1; idle(50);
      coin_sense = 1'b0;
      push(K_REJ, cyc + LAT);
      idle(40);

      // Stuck sensor
      coin_sense = 1'b1;
      push(K_JAM, cyc + JAM_RISE);
      idle(400);
      check("jam_held", int'(jam), 1);
      coin_sense = 1'b0;
      push(K_REJ, cyc + LAT_JAM);
      idle(40);
      check("jam_released", int'(jam), 0);

      // Second coin arrives during lockout: valid width but always rejected
      coin_sense = 1'b1; idle(30);
      coin_sense = 1'b0;
      push(K_RS5, cyc + LAT);
      idle(6);
      coin(30, K_REJ);

      // Reset late in a 30-cycle coin: two post-reset samples are filtered out
      coin_sense = 1'b1; idle(27);
      rst = 1'b1; idle(1);
      check("midreset_code", int'(coin_code), 0);
      check("midreset_valid", int'(coin_valid), 0);
      check("midreset_reject", int'(coin_reject), 0);
      check("midreset_jam", int'(jam), 0);
      rst = 1'b0; idle(2);
      coin_sense = 1'b0;
      idle(40);
      coin(30, K_RS5);

      idle(20);
      check("pending_events", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
